// File: rtl/riscv_pkg.sv
// riscv_pkg: CSR addresses, mstatus field positions and privilege encodings
package riscv_pkg;
    typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} priv_e;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 12;
endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: execute writeback/trap signals and decode read port of the CSR file
interface csr_file_if #(parameter int XLEN = 32);
    logic            csr_wbk_v_i;
    logic [11:0]     csr_adr_i;
    logic [XLEN-1:0] csr_data_i;
    logic            exception_i;
    logic [XLEN-1:0] mcause_i;
    logic [XLEN-1:0] mtval_i;
    logic [XLEN-1:0] mepc_i;
    logic            mret_i;
    logic [1:0]      core_mode_i;
    logic            instret_i;
    logic [11:0]     csr_rd_adr_i;
    logic            csr_rd_wr_i;
    logic [XLEN-1:0] csr_rd_data_o;
    logic            csr_rd_illegal_o;
    logic [XLEN-1:0] mepc_q_o;
    logic [XLEN-1:0] mtvec_q_o;
    logic [XLEN-1:0] mstatus_q_o;
    modport master (
        output csr_wbk_v_i, csr_adr_i, csr_data_i, exception_i, mcause_i, mtval_i, mepc_i,
               mret_i, core_mode_i, instret_i, csr_rd_adr_i, csr_rd_wr_i,
        input  csr_rd_data_o, csr_rd_illegal_o, mepc_q_o, mtvec_q_o, mstatus_q_o
    );
    modport slave (
        input  csr_wbk_v_i, csr_adr_i, csr_data_i, exception_i, mcause_i, mtval_i, mepc_i,
               mret_i, core_mode_i, instret_i, csr_rd_adr_i, csr_rd_wr_i,
        output csr_rd_data_o, csr_rd_illegal_o, mepc_q_o, mtvec_q_o, mstatus_q_o
    );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and independently writable halves
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] data,
    output logic [63:0] q
);
    // a write to either half freezes the whole counter for that cycle
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (wr_lo) q[31:0] <= data;
        else if (wr_hi) q[63:32] <= data;
        else if (inc) q <= q + 64'd1;
    end
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, trap/mret state updates and decode read port
module csr_file
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] MISA_VAL = 'h4000_0100,
    parameter logic [XLEN-1:0] HART_ID  = '0
) (
    input logic clk,
    input logic reset,
    csr_file_if.slave bus
);
    localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(32'h0000_1888);
    localparam logic [XLEN-1:0] MIE_MASK     = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);
    logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, rd_data;
    logic [63:0] mcycle, minstret;
    logic wr, mapped;
    // an exception swallows any writeback in the same cycle, counters included
    assign wr = bus.csr_wbk_v_i && !bus.exception_i;
    always_ff @(posedge clk) begin
        if (reset) begin
            {mstatus, mie, mtvec, mscratch, mepc, mcause, mtval} <= '0;
        end else if (bus.exception_i) begin
            mepc <= bus.mepc_i & ALIGN_MASK;
            mcause <= bus.mcause_i;
            mtval <= bus.mtval_i;
            mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
            mstatus[MSTATUS_MIE] <= 1'b0;
            mstatus[MSTATUS_MPP -: 2] <= bus.core_mode_i;
        end else begin
            if (bus.mret_i) begin
                mstatus[MSTATUS_MIE] <= mstatus[MSTATUS_MPIE];
                mstatus[MSTATUS_MPIE] <= 1'b1;
                mstatus[MSTATUS_MPP -: 2] <= 2'b00;
            end
            if (wr) begin
                case (bus.csr_adr_i)
                    CSR_MSTATUS:  if (!bus.mret_i) mstatus <= bus.csr_data_i & MSTATUS_MASK;
                    CSR_MIE:      mie <= bus.csr_data_i & MIE_MASK;
                    CSR_MTVEC:    mtvec <= bus.csr_data_i & ALIGN_MASK;
                    CSR_MSCRATCH: mscratch <= bus.csr_data_i;
                    CSR_MEPC:     mepc <= bus.csr_data_i & ALIGN_MASK;
                    CSR_MCAUSE:   mcause <= bus.csr_data_i;
                    CSR_MTVAL:    mtval <= bus.csr_data_i;
                    default: ;
                endcase
            end
        end
    end
    csr_counter64 u_mcycle (
        .clk(clk), .reset(reset), .inc(1'b1),
        .wr_lo(wr && bus.csr_adr_i == CSR_MCYCLE), .wr_hi(wr && bus.csr_adr_i == CSR_MCYCLEH),
        .data(bus.csr_data_i), .q(mcycle)
    );
    csr_counter64 u_minstret (
        .clk(clk), .reset(reset), .inc(bus.instret_i && !bus.exception_i),
        .wr_lo(wr && bus.csr_adr_i == CSR_MINSTRET), .wr_hi(wr && bus.csr_adr_i == CSR_MINSTRETH),
        .data(bus.csr_data_i), .q(minstret)
    );
    always_comb begin
        rd_data = '0;
        mapped = 1'b1;
        case (bus.csr_rd_adr_i)
            CSR_MSTATUS:               rd_data = mstatus;
            CSR_MISA:                  rd_data = MISA_VAL;
            CSR_MIE:                   rd_data = mie;
            CSR_MTVEC:                 rd_data = mtvec;
            CSR_MSCRATCH:              rd_data = mscratch;
            CSR_MEPC:                  rd_data = mepc;
            CSR_MCAUSE:                rd_data = mcause;
            CSR_MTVAL:                 rd_data = mtval;
            CSR_MIP:                   rd_data = '0;
            CSR_MHARTID:               rd_data = HART_ID;
            CSR_MCYCLE, CSR_CYCLE:     rd_data = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   rd_data = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: rd_data = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_data = minstret[63:32];
            default:                   mapped = 1'b0;
        endcase
    end
    assign bus.csr_rd_data_o = rd_data;
    assign bus.csr_rd_illegal_o = !mapped || (bus.csr_rd_wr_i && bus.csr_rd_adr_i[11:10] == 2'b11)
                                  || (bus.csr_rd_adr_i[9:8] > bus.core_mode_i);
    assign bus.mepc_q_o = mepc;
    assign bus.mtvec_q_o = mtvec;
    assign bus.mstatus_q_o = mstatus;
endmodule
